psum_lane_packer: RTL and testbench

- Serial-to-parallel packer that feeds the 16-lane 16-bit adder tree. PE products arrive one 16-bit signed value per cycle on a valid/ready stream.
- Lanes are assembled into a 256-bit word, lane i at bits [(i+1)*16-1 : i*16]. The word is presented on a registered valid/ready output, to be consumed directly as the adder tree's 256-bit input.
- Sits between the PE column output and the reduction adder.

---
 rtl/psum_lane_packer_if.sv | 40 ++++
 rtl/psum_lane_packer.sv | 112 +++++++++++
 tb/tb_psum_lane_packer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_lane_packer_if.sv
// psum_lane_packer_if
//   Stream bundle between the PE column and the lane packer, and between the
//   packer and the adder tree.
//   slave  : packer side (consumes in_*, produces out_*)
//   master : environment side (produces in_*, consumes out_*)
//   Signals:
//     in_data   DATA_W      signed lane value
//     in_valid  1           in_data valid
//     in_ready  1           packer can accept in_data this cycle
//     in_last   1           final lane of a short group (PACK_LAST_PAD_EN only)
//     out_data  LANES*DATA_W packed word, lane 0 in LSBs
//     out_valid 1           out_data valid
//     out_ready 1           downstream accepts out_data
//     out_lanes CNT_W+1     number of real (non-padded) lanes in out_data
interface psum_lane_packer_if #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16
);
    localparam int OUT_W = LANES * DATA_W;
    localparam int CNT_W = $clog2(LANES);

    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [OUT_W-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CNT_W:0]           out_lanes;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_lanes
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_lanes
    );
endinterface

// File: rtl/psum_lane_packer.sv
// psum_lane_packer
//   Serial-to-parallel packer feeding the LANES-lane adder tree. One signed
//   lane value is accepted per cycle and written into an assembly register;
//   when the word is complete it moves to a registered output slot.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     clear    synchronous discard of the partial assembly (output slot kept)
//     bus      psum_lane_packer_if.slave (input stream + packed output word)
//   Build option:
//     PACK_LAST_PAD_EN  when defined, in_last closes a word early and the
//                       unfilled upper lanes are zero; otherwise in_last is
//                       ignored and every word carries LANES lanes.
module psum_lane_packer #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    psum_lane_packer_if.slave  bus
);
    localparam int OUT_W = LANES * DATA_W;
    localparam int CNT_W = $clog2(LANES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W:0]   out_lanes_q, out_lanes_d;

    logic [OUT_W-1:0] word_d;
    logic             final_lane;
    logic             early_last;
    logic             in_ready;
    logic             accept;
    logic             complete;

    assign final_lane = (cnt_q == CNT_W'(LANES - 1));

`ifdef PACK_LAST_PAD_EN
    assign early_last = bus.in_last;
`else
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
    assign early_last     = 1'b0;
`endif

    // A word-closing lane needs the output slot to be empty or draining now;
    // any other lane only lands in the assembly register and is always taken.
    assign in_ready = ~clear & (~(final_lane | early_last) | ~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign complete = accept & (final_lane | early_last);

    always_comb begin
        // Lanes above cnt are zero in the assembly register, so dropping the
        // incoming value into lane cnt yields the finished (or padded) word.
        word_d = asm_q;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                word_d[i*DATA_W +: DATA_W] = bus.in_data;
            end
        end

        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_lanes_d = out_lanes_q;

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (accept) begin
            if (complete) begin
                cnt_d       = '0;
                asm_d       = '0;
                out_data_d  = word_d;
                out_lanes_d = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                asm_d = word_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_lanes_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_lanes_q <= out_lanes_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lanes = out_lanes_q;
endmodule

// File: tb/tb_psum_lane_packer.sv
module tb_psum_lane_packer;
    localparam int LANES  = 16;
    localparam int DATA_W = 16;
    localparam int OUT_W  = LANES * DATA_W;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clear   = 1'b0;

    always #5 clk = ~clk;

    psum_lane_packer_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

    psum_lane_packer #(.LANES(LANES), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        clr;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic        chk;
        logic [4:0]  exp_lanes;
        logic [15:0] exp_l0;
        logic [15:0] exp_l15;
    } vec_t;

    vec_t tbl [44];

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic clr,
                                input logic ordy, input logic er, input logic eov,
                                input logic chk, input logic [4:0] el,
                                input logic [15:0] l0, input logic [15:0] l15);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.ordy = ordy; r.exp_rdy = er;
        r.exp_ov = eov; r.chk = chk; r.exp_lanes = el; r.exp_l0 = l0; r.exp_l15 = l15;
        return r;
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l,
                         input logic c, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        clear         = c;
        bus.out_ready = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [OUT_W-1:0] exp_w;
        logic [OUT_W-1:0] word1;
        int acc;

        // ---------------- reset state ----------------
        drive(0, 16'h0, 0, 0, 0);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_lanes", bus.out_lanes, 0);
        check("rst_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- 16 lanes 1..16 ----------------
        exp_w = '0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'(i + 1), 0, 0, 1);
            check("seq16_in_ready", bus.in_ready, 1);
            check("seq16_no_early_valid", bus.out_valid, 0);
            exp_w[i*16 +: 16] = 16'(i + 1);
            step();
        end
        drive(0, 16'h0, 0, 0, 1);
        check("seq16_out_valid", bus.out_valid, 1);
        check("seq16_out_data",  bus.out_data,  exp_w);
        check("seq16_lane0",     bus.out_data[15:0], 16'h0001);
        check("seq16_lane15",    bus.out_data[255:240], 16'h0010);
        check("seq16_out_lanes", bus.out_lanes, 16);
        step();
        check("seq16_drained",   bus.out_valid, 0);
        check("seq16_data_hold", bus.out_data,  exp_w);

        // ---------------- table-driven vectors ----------------
        tbl[0] = mk(1, 16'h8000, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i < 15; i++) tbl[i] = mk(1, 16'h7000 + 16'(i), 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 16'hFFFF, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 16'h0, 0, 0, 1, 1, 1, 16, 16'h8000, 16'hFFFF);
        tbl[17] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16, 16'h8000, 16'hFFFF);
        tbl[18] = mk(0, 16'h0, 0, 0, 1, 0, 1, 16, 16'h8000, 16'hFFFF);
        for (int i = 19; i < 26; i++) tbl[i] = mk(1, 16'h00C0 + 16'(i), 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[26] = mk(1, 16'hDEAD, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 27; i < 43; i++) tbl[i] = mk(1, 16'h0D00 + 16'(i - 27), 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[43] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16, 16'h0D00, 16'h0D0F);

        for (int r = 0; r < 44; r++) begin
            drive(tbl[r].v, tbl[r].d, 0, tbl[r].clr, tbl[r].ordy);
            check("tbl_in_ready",  bus.in_ready,  tbl[r].exp_rdy);
            check("tbl_out_valid", bus.out_valid, tbl[r].exp_ov);
            if (tbl[r].chk) begin
                check("tbl_out_lanes", bus.out_lanes, tbl[r].exp_lanes);
                check("tbl_lane0",     bus.out_data[15:0], tbl[r].exp_l0);
                check("tbl_lane15",    bus.out_data[255:240], tbl[r].exp_l15);
            end
            step();
        end
        drive(0, 16'h0, 0, 0, 1);
        step();

        // ---------------- 48 lanes streamed ----------------
        acc = 0;
        for (int i = 0; i < 48; i++) begin
            drive(1, 16'h0100 + 16'(i), 0, 0, 1);
            check("stream_in_ready", bus.in_ready, 1);
            step();
            acc++;
            check("stream_out_valid", bus.out_valid, (acc % 16 == 0) ? 1 : 0);
            if (acc % 16 == 0) begin
                exp_w = '0;
                for (int j = 0; j < 16; j++) exp_w[j*16 +: 16] = 16'h0100 + 16'(acc - 16 + j);
                check("stream_word", bus.out_data, exp_w);
            end
        end
        drive(0, 16'h0, 0, 0, 1);
        step();
        check("stream_idle", bus.out_valid, 0);

        // ---------------- backpressure on final lane ----------------
        word1 = '0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'h2000 + 16'(i), 0, 0, 0);
            word1[i*16 +: 16] = 16'h2000 + 16'(i);
            step();
        end
        exp_w = '0;
        for (int i = 0; i < 15; i++) begin
            drive(1, 16'h3000 + 16'(i), 0, 0, 0);
            check("bp_fill_in_ready", bus.in_ready, 1);
            exp_w[i*16 +: 16] = 16'h3000 + 16'(i);
            step();
        end
        exp_w[255:240] = 16'hBEEF;
        drive(1, 16'hBEEF, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_hold_valid",   bus.out_valid, 1);
            check("bp_hold_data",    bus.out_data, word1);
            step();
        end
        drive(1, 16'hBEEF, 0, 0, 1);
        check("bp_release_ready", bus.in_ready, 1);
        step();
        drive(0, 16'h0, 0, 0, 0);
        check("bp_word2_valid", bus.out_valid, 1);
        check("bp_word2_data",  bus.out_data, exp_w);
        check("bp_word2_lanes", bus.out_lanes, 16);
        drive(0, 16'h0, 0, 0, 1);
        step();
        check("bp_drained", bus.out_valid, 0);

        // ---------------- async reset mid-word ----------------
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'h4000 + 16'(i), 0, 0, 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'h4100 + 16'(i), 0, 0, 0);
            step();
        end
        drive(0, 16'h0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data",  bus.out_data, 0);
        check("arst_out_lanes", bus.out_lanes, 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_w = '0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'h5000 + 16'(i), 0, 0, 1);
            exp_w[i*16 +: 16] = 16'h5000 + 16'(i);
            step();
            check("arst_valid_timing", bus.out_valid, (i == 15) ? 1 : 0);
        end
        drive(0, 16'h0, 0, 0, 1);
        check("arst_clean_word", bus.out_data, exp_w);
        step();

        // ---------------- in_last short group ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1, 16'h0A0A, (i == 4) ? 1'b1 : 1'b0, 0, 1);
            step();
        end
        exp_w = '0;
        for (int j = 0; j < 5; j++) exp_w[j*16 +: 16] = 16'h0A0A;
        drive(0, 16'h0, 0, 0, 1);
`ifdef PACK_LAST_PAD_EN
        check("last_out_valid", bus.out_valid, 1);
        check("last_out_lanes", bus.out_lanes, 5);
        check("last_out_data",  bus.out_data, exp_w);
        step();
        check("last_drained", bus.out_valid, 0);
        drive(1, 16'h0C0C, 1, 0, 1);
        step();
        drive(0, 16'h0, 0, 0, 1);
        exp_w = '0;
        exp_w[15:0] = 16'h0C0C;
        check("last_single_lanes", bus.out_lanes, 1);
        check("last_single_data",  bus.out_data, exp_w);
        step();
`else
        check("nolast_no_output", bus.out_valid, 0);
        for (int i = 5; i < 16; i++) begin
            drive(1, 16'h0B0B, 0, 0, 1);
            exp_w[i*16 +: 16] = 16'h0B0B;
            step();
            check("nolast_valid_timing", bus.out_valid, (i == 15) ? 1 : 0);
        end
        drive(0, 16'h0, 0, 0, 1);
        check("nolast_out_lanes", bus.out_lanes, 16);
        check("nolast_out_data",  bus.out_data, exp_w);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
